// File: rtl/id_ctrl_stage_if.sv
// -----------------------------------------------------------------------------
// id_ctrl_stage_if
// Bundles the IF-side and EX-side signals of the ID control stage.
//   IF side : instr_i, instr_valid_i (to ID), stall_o (to IF)
//   EX side : flush_i, ex_ready_i (to ID), ex_valid_o plus the registered
//             control word and register fields (to EX)
// Modports:
//   master - the environment around the stage (drives IF/EX requests)
//   slave  - id_ctrl_stage itself
// -----------------------------------------------------------------------------
interface id_ctrl_stage_if #(
  parameter int ALU_OP_W   = 5,
  parameter int REG_ADDR_W = 5
);
  logic [31:0]           instr_i;
  logic                  instr_valid_i;
  logic                  flush_i;
  logic                  ex_ready_i;
  logic                  stall_o;
  logic                  ex_valid_o;
  logic                  RegWrite_o;
  logic                  ALUSrc_o;
  logic                  Branch_o;
  logic                  Jump_o;
  logic                  MemRead_o;
  logic                  MemWrite_o;
  logic [ALU_OP_W-1:0]   ALU_op_o;
  logic [1:0]            RegDst_o;
  logic [2:0]            BranchType_o;
  logic [1:0]            MemtoReg_o;
  logic [REG_ADDR_W-1:0] rs_o;
  logic [REG_ADDR_W-1:0] rt_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic                  illegal_o;

  modport master (
    output instr_i, instr_valid_i, flush_i, ex_ready_i,
    input  stall_o, ex_valid_o, RegWrite_o, ALUSrc_o, Branch_o, Jump_o,
           MemRead_o, MemWrite_o, ALU_op_o, RegDst_o, BranchType_o,
           MemtoReg_o, rs_o, rt_o, rd_o, illegal_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, ex_ready_i,
    output stall_o, ex_valid_o, RegWrite_o, ALUSrc_o, Branch_o, Jump_o,
           MemRead_o, MemWrite_o, ALU_op_o, RegDst_o, BranchType_o,
           MemtoReg_o, rs_o, rt_o, rd_o, illegal_o
  );
endinterface

// File: rtl/id_ctrl_stage.sv
// -----------------------------------------------------------------------------
// id_ctrl_stage
// Instruction-decode control stage between IF and EX. Decodes the 32-bit
// instruction into a control word and registers it into the ID/EX control
// register with a valid bit. Handles EX back-pressure, load-use bubbling,
// flush on taken branch/jump and illegal-opcode flagging.
// Ports:
//   clk_i, rst_i - clock; asynchronous active-high reset
//   bus          - id_ctrl_stage_if.slave (IF request/stall, EX control word)
// Optional feature (macro MUL_STALL_EN): an accepted MUL (R-type, funct 0x18)
// holds the stage in BUSY for MUL_LAT-1 cycles, issuing bubbles meanwhile.
// -----------------------------------------------------------------------------
module id_ctrl_stage #(
  parameter int ALU_OP_W   = 5,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  id_ctrl_stage_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLT  = 6'h06;
  localparam logic [5:0] OP_BLE  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_BNEZ = 6'h15;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  if (MUL_LAT < 1) begin : gBadMulLat
    $error("MUL_LAT must be at least 1");
  end

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic                  regWrite;
    logic                  aluSrc;
    logic                  branch;
    logic                  jump;
    logic                  memRead;
    logic                  memWrite;
    logic [ALU_OP_W-1:0]   aluOp;
    logic [1:0]            regDst;
    logic [2:0]            branchType;
    logic [1:0]            memToReg;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } ctrlWord_t;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] inRs;
  logic [REG_ADDR_W-1:0] inRt;
  logic                  unusedBits;
  ctrlWord_t             dec;
  ctrlWord_t             ctrlQ;
  logic                  usesRt;
  logic                  loadUse;
  logic                  busy;
  logic                  stall;

  assign opcode     = bus.instr_i[31:26];
  assign inRs       = REG_ADDR_W'(bus.instr_i[25:21]);
  assign inRt       = REG_ADDR_W'(bus.instr_i[20:16]);
  assign unusedBits = ^bus.instr_i[10:0];

  // Combinational decode of the incoming instruction.
  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec       = '0;
    dec.valid = 1'b1;
    dec.rs    = inRs;
    dec.rt    = inRt;
    dec.rd    = REG_ADDR_W'(bus.instr_i[15:11]);
    unique case (opcode)
      OP_R:    begin dec.aluOp = ALU_OP_W'(2);  dec.regWrite = 1'b1; dec.regDst = 2'd1; end
      OP_ADDI: begin dec.aluOp = ALU_OP_W'(0);  dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      OP_BEQ:  begin dec.aluOp = ALU_OP_W'(1);  dec.branch = 1'b1; dec.branchType = 3'd1; end
      OP_BNE:  begin dec.aluOp = ALU_OP_W'(3);  dec.branch = 1'b1; dec.branchType = 3'd2; end
      OP_ORI:  begin dec.aluOp = ALU_OP_W'(4);  dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      OP_LUI:  begin dec.aluOp = ALU_OP_W'(5);  dec.aluSrc = 1'b1; dec.regWrite = 1'b1; end
      OP_LW:   begin
        dec.aluOp    = ALU_OP_W'(6);
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.memRead  = 1'b1;
        dec.memToReg = 2'd1;
      end
      OP_SW:   begin dec.aluOp = ALU_OP_W'(7);  dec.aluSrc = 1'b1; dec.memWrite = 1'b1; end
      OP_J:    begin dec.aluOp = ALU_OP_W'(8);  dec.jump = 1'b1; end
      OP_JAL:  begin dec.aluOp = ALU_OP_W'(9);  dec.jump = 1'b1; dec.regWrite = 1'b1; dec.regDst = 2'd2; end
      OP_BLE:  begin dec.aluOp = ALU_OP_W'(10); dec.branch = 1'b1; dec.branchType = 3'd3; end
      OP_BLT:  begin dec.aluOp = ALU_OP_W'(11); dec.branch = 1'b1; dec.branchType = 3'd4; end
      OP_BNEZ: begin dec.aluOp = ALU_OP_W'(12); dec.branch = 1'b1; dec.branchType = 3'd5; end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Instructions that read rt as a source operand (rs is always a source).
  always_comb begin
    usesRt = 1'b0;
    case (opcode)
      OP_R, OP_BEQ, OP_BNE, OP_BLE, OP_BLT, OP_BNEZ, OP_SW: usesRt = 1'b1;
      default:                                               usesRt = 1'b0;
    endcase
  end

  // Load-use: the word now in EX loads a nonzero register the incoming
  // instruction needs next cycle.
  assign loadUse = ctrlQ.valid && ctrlQ.memRead && (ctrlQ.rt != '0) &&
                   bus.instr_valid_i &&
                   ((ctrlQ.rt == inRs) || (usesRt && (ctrlQ.rt == inRt)));

  // Flush overrides every stall source.
  assign stall = !bus.flush_i && (!bus.ex_ready_i || loadUse || busy);

`ifdef MUL_STALL_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {RUN, BUSY} state_e;

  state_e            state;
  state_e            stateNext;
  logic [CNT_W-1:0]  mulCnt;
  logic [CNT_W-1:0]  mulCntNext;
  logic              accept;

  assign busy   = (state == BUSY);
  assign accept = bus.instr_valid_i && !stall && !bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= RUN;
      mulCnt <= '0;
    end else begin
      state  <= stateNext;
      mulCnt <= mulCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    mulCntNext = mulCnt;
    if (bus.flush_i) begin
      stateNext  = RUN;
      mulCntNext = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept && (opcode == OP_R) && (bus.instr_i[5:0] == 6'h18) && (MUL_LAT > 1)) begin
            stateNext  = BUSY;
            mulCntNext = CNT_W'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (bus.ex_ready_i) begin
            mulCntNext = mulCnt - 1'b1;
            if (mulCntNext == '0) stateNext = RUN;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end
`else
  assign busy = 1'b0;
`endif

  // ID/EX control register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the control word is plain flops, so it is cleared on reset; sequential
    // state is always written with non-blocking assignments.
    if (rst_i) begin
      ctrlQ <= '0;
    end else if (bus.flush_i) begin
      ctrlQ <= '0;
    end else if (!bus.ex_ready_i) begin
      ctrlQ <= ctrlQ;
    end else if (busy || loadUse || !bus.instr_valid_i) begin
      ctrlQ <= '0;
    end else begin
      ctrlQ <= dec;
    end
  end

  assign bus.stall_o      = stall;
  assign bus.ex_valid_o   = ctrlQ.valid;
  assign bus.illegal_o    = ctrlQ.illegal;
  assign bus.RegWrite_o   = ctrlQ.regWrite;
  assign bus.ALUSrc_o     = ctrlQ.aluSrc;
  assign bus.Branch_o     = ctrlQ.branch;
  assign bus.Jump_o       = ctrlQ.jump;
  assign bus.MemRead_o    = ctrlQ.memRead;
  assign bus.MemWrite_o   = ctrlQ.memWrite;
  assign bus.ALU_op_o     = ctrlQ.aluOp;
  assign bus.RegDst_o     = ctrlQ.regDst;
  assign bus.BranchType_o = ctrlQ.branchType;
  assign bus.MemtoReg_o   = ctrlQ.memToReg;
  assign bus.rs_o         = ctrlQ.rs;
  assign bus.rt_o         = ctrlQ.rt;
  assign bus.rd_o         = ctrlQ.rd;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ctrl_stage
// Self-checking bench for id_ctrl_stage: directed scenarios followed by a
// randomized stream, all compared against a table-driven reference model.
// Follows MUL_STALL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_id_ctrl_stage;

  localparam int MUL_LAT = 4;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       regWrite;
    logic       aluSrc;
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic [4:0] aluOp;
    logic [1:0] regDst;
    logic [2:0] branchType;
    logic [1:0] memToReg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    int         alu;
    bit         rw, as, br, jp, mr, mw;
    int         rdst, bt, m2r;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  row_t rows [13];
  obs_t model;
  int   busyLeft;
  bit   lastStall;

  id_ctrl_stage_if #(.ALU_OP_W(5), .REG_ADDR_W(5)) bus ();

  id_ctrl_stage #(.ALU_OP_W(5), .REG_ADDR_W(5), .MUL_LAT(MUL_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] funct);
    return {op, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic obs_t getObs();
    obs_t o;
    o.valid      = bus.ex_valid_o;
    o.illegal    = bus.illegal_o;
    o.regWrite   = bus.RegWrite_o;
    o.aluSrc     = bus.ALUSrc_o;
    o.branch     = bus.Branch_o;
    o.jump       = bus.Jump_o;
    o.memRead    = bus.MemRead_o;
    o.memWrite   = bus.MemWrite_o;
    o.aluOp      = bus.ALU_op_o;
    o.regDst     = bus.RegDst_o;
    o.branchType = bus.BranchType_o;
    o.memToReg   = bus.MemtoReg_o;
    o.rs         = bus.rs_o;
    o.rt         = bus.rt_o;
    o.rd         = bus.rd_o;
    return o;
  endfunction

  // Table lookup: any opcode not in the table is illegal with all control 0.
  function automatic obs_t refDecode(input logic [31:0] ins);
    obs_t w = '0;
    bit found = 1'b0;
    w.valid = 1'b1;
    w.rs    = ins[25:21];
    w.rt    = ins[20:16];
    w.rd    = ins[15:11];
    foreach (rows[i]) begin
      if (rows[i].op == ins[31:26]) begin
        found        = 1'b1;
        w.aluOp      = 5'(rows[i].alu);
        w.regWrite   = rows[i].rw;
        w.aluSrc     = rows[i].as;
        w.branch     = rows[i].br;
        w.jump       = rows[i].jp;
        w.memRead    = rows[i].mr;
        w.memWrite   = rows[i].mw;
        w.regDst     = 2'(rows[i].rdst);
        w.branchType = 3'(rows[i].bt);
        w.memToReg   = 2'(rows[i].m2r);
      end
    end
    if (!found) w.illegal = 1'b1;
    return w;
  endfunction

  function automatic bit readsRt(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h15, 6'h2b};
  endfunction

  // One clock of stimulus: drive, check stall mid-cycle, advance the model,
  // then check the registered word just after the edge.
  task automatic step(input logic [31:0] ins, input logic v, input logic f, input logic r);
    obs_t nxt;
    bit   haz;
    bit   expStall;
    bus.instr_i       = ins;
    bus.instr_valid_i = v;
    bus.flush_i       = f;
    bus.ex_ready_i    = r;
    #3;
    haz = model.valid && model.memRead && (model.rt != 5'd0) && v &&
          ((model.rt == ins[25:21]) || (readsRt(ins[31:26]) && (model.rt == ins[20:16])));
    expStall = !f && (!r || haz || (busyLeft > 0));
    check("stall", 64'(bus.stall_o), 64'(expStall));
    lastStall = expStall;
    nxt = model;
    if (f) begin
      nxt      = '0;
      busyLeft = 0;
    end else if (!r) begin
      nxt = model;
    end else if (busyLeft > 0) begin
      nxt = '0;
      busyLeft--;
    end else if (haz || !v) begin
      nxt = '0;
    end else begin
      nxt = refDecode(ins);
`ifdef MUL_STALL_EN
      if (ins[31:26] == 6'h00 && ins[5:0] == 6'h18) busyLeft = MUL_LAT - 1;
`endif
    end
    @(posedge clk);
    #1;
    model = nxt;
    check("word", 64'(getObs()), 64'(model));
  endtask

  initial begin
    logic [31:0] ins;
    logic        v;
    logic [5:0]  ops [16];
    logic [31:0] addi, ori, lui, sw, jal, lw8, add8, lw0, add0, bne, ill, mul;

    rows[0]  = '{6'h00, 2,  1,0,0,0,0,0, 1,0,0};
    rows[1]  = '{6'h08, 0,  1,1,0,0,0,0, 0,0,0};
    rows[2]  = '{6'h04, 1,  0,0,1,0,0,0, 0,1,0};
    rows[3]  = '{6'h05, 3,  0,0,1,0,0,0, 0,2,0};
    rows[4]  = '{6'h0d, 4,  1,1,0,0,0,0, 0,0,0};
    rows[5]  = '{6'h0f, 5,  1,1,0,0,0,0, 0,0,0};
    rows[6]  = '{6'h23, 6,  1,1,0,0,1,0, 0,0,1};
    rows[7]  = '{6'h2b, 7,  0,1,0,0,0,1, 0,0,0};
    rows[8]  = '{6'h02, 8,  0,0,0,1,0,0, 0,0,0};
    rows[9]  = '{6'h03, 9,  1,0,0,1,0,0, 2,0,0};
    rows[10] = '{6'h07, 10, 0,0,1,0,0,0, 0,3,0};
    rows[11] = '{6'h06, 11, 0,0,1,0,0,0, 0,4,0};
    rows[12] = '{6'h15, 12, 0,0,1,0,0,0, 0,5,0};

    addi = mk(6'h08, 5'd1, 5'd2, 5'd3, 6'h04);
    ori  = mk(6'h0d, 5'd4, 5'd5, 5'd0, 6'h0f);
    lui  = mk(6'h0f, 5'd0, 5'd6, 5'd1, 6'h00);
    sw   = mk(6'h2b, 5'd2, 5'd7, 5'd0, 6'h08);
    jal  = mk(6'h03, 5'd3, 5'd1, 5'd2, 6'h10);
    lw8  = mk(6'h23, 5'd2, 5'd8, 5'd0, 6'h00);
    add8 = mk(6'h00, 5'd8, 5'd1, 5'd9, 6'h20);
    lw0  = mk(6'h23, 5'd2, 5'd0, 5'd0, 6'h00);
    add0 = mk(6'h00, 5'd0, 5'd0, 5'd4, 6'h20);
    bne  = mk(6'h05, 5'd1, 5'd2, 5'd0, 6'h03);
    ill  = mk(6'h3f, 5'd1, 5'd2, 5'd3, 6'h00);
    mul  = mk(6'h00, 5'd3, 5'd4, 5'd5, 6'h18);

    // Reset state.
    bus.instr_i = '0; bus.instr_valid_i = 1'b0; bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
    model = '0; busyLeft = 0; lastStall = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_word", 64'(getObs()), 64'(model));
    check("reset_stall", 64'(bus.stall_o), 64'd0);
    #1 rst = 1'b0;

    // Back-to-back stream.
    step(addi, 1, 0, 1);
    step(ori,  1, 0, 1);
    step(lui,  1, 0, 1);
    step(sw,   1, 0, 1);
    check("sw_memwrite", 64'(bus.MemWrite_o), 64'd1);
    check("sw_aluop", 64'(bus.ALU_op_o), 64'd7);
    step(jal,  1, 0, 1);
    check("jal_regdst", 64'(bus.RegDst_o), 64'd2);
    check("jal_jump", 64'(bus.Jump_o), 64'd1);
    check("jal_aluop", 64'(bus.ALU_op_o), 64'd9);

    // Load-use: one bubble, then the held ADD issues.
    step(lw8,  1, 0, 1);
    step(add8, 1, 0, 1);
    check("lu_stall", 64'(lastStall), 64'd1);
    check("lu_bubble", 64'(bus.ex_valid_o), 64'd0);
    step(add8, 1, 0, 1);
    check("lu_issue", 64'({bus.ex_valid_o, bus.rd_o}), 64'({1'b1, 5'd9}));

    // Load to $0: no bubble.
    step(lw0,  1, 0, 1);
    step(add0, 1, 0, 1);
    check("lu_r0_nostall", 64'(lastStall), 64'd0);
    check("lu_r0_valid", 64'(bus.ex_valid_o), 64'd1);

    // Back-pressure with BNE registered.
    step(bne,  1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(addi, 1, 0, 0);
      check("bp_stall", 64'(lastStall), 64'd1);
      check("bp_btype", 64'({bus.ex_valid_o, bus.BranchType_o}), 64'({1'b1, 3'd2}));
    end
    step(addi, 1, 0, 1);

    // Flush together with a load-use hazard.
    step(lw8,  1, 0, 1);
    step(add8, 1, 1, 1);
    check("flush_nostall", 64'(lastStall), 64'd0);
    check("flush_bubble", 64'(bus.ex_valid_o), 64'd0);
    step(add8, 1, 0, 1);
    check("flush_after", 64'(bus.ex_valid_o), 64'd1);

    // Illegal opcode pulses for one cycle.
    step(ill,  1, 0, 1);
    check("illegal_pulse", 64'({bus.ex_valid_o, bus.illegal_o, bus.RegWrite_o, bus.ALU_op_o}),
          64'({1'b1, 1'b1, 1'b0, 5'd0}));
    step(addi, 1, 0, 1);
    check("illegal_clear", 64'(bus.illegal_o), 64'd0);

`ifdef MUL_STALL_EN
    // MUL: MUL_LAT-1 bubbles, then the held ADDI issues.
    step(mul, 1, 0, 1);
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      step(addi, 1, 0, 1);
      check("mul_bubble", 64'(bus.ex_valid_o), 64'd0);
    end
    step(addi, 1, 0, 1);
    check("mul_done", 64'(bus.ex_valid_o), 64'd1);
    // Flush while BUSY.
    step(mul,  1, 0, 1);
    step(addi, 1, 0, 1);
    step(addi, 1, 1, 1);
    check("mul_flush_nostall", 64'(lastStall), 64'd0);
    step(addi, 1, 0, 1);
    check("mul_flush_run", 64'(bus.ex_valid_o), 64'd1);
`else
    // MUL is a plain R-type.
    step(mul,  1, 0, 1);
    step(addi, 1, 0, 1);
    check("mul_single_issue", 64'(lastStall), 64'd0);
`endif

    // Asynchronous reset while LW is registered.
    step(lw8, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    model = '0; busyLeft = 0; lastStall = 1'b0;
    check("async_reset", 64'(getObs()), 64'(model));
    @(posedge clk);
    #2 rst = 1'b0;

    // Randomized stream; IF holds the instruction while stalled.
    ops = '{6'h00, 6'h08, 6'h04, 6'h05, 6'h0d, 6'h0f, 6'h23, 6'h2b,
            6'h02, 6'h03, 6'h07, 6'h06, 6'h15, 6'h23, 6'h3f, 6'h11};
    ins = addi;
    v   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!lastStall) begin
        ins = mk(ops[$urandom_range(15)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(31)), ($urandom_range(5) == 0) ? 6'h18 : 6'h20);
        v   = ($urandom_range(7) != 0);
      end
      step(ins, v, ($urandom_range(15) == 0), ($urandom_range(4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
